// File: rtl/bin14_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin14_to_bcd_seq
//   Sequential shift-add-3 (double-dabble) binary-to-BCD converter for the
//   counter display path. One conversion takes BIN_W shift cycles plus one
//   settle cycle in SHIFT and one DONE cycle. Results are saturated to all
//   nines, with ovf set, when the value needs more than DIGITS digits.
//   bcd/ovf are loaded only on the edge entering DONE, so the digit mux
//   never sees partial data.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, accepted in IDLE or DONE
//   bin    in   BIN_W-bit unsigned value, captured on accepted start
//   busy   out  high while shifting
//   done   out  one-cycle pulse, bcd/ovf valid and freshly updated
//   bcd    out  packed BCD, [3:0] = ones; held until next done
//   ovf    out  last value exceeded DIGITS decimal digits; held with bcd
// ----------------------------------------------------------------------------
module bin14_to_bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   // One spare digit in the scratch so the full input range converts
   // without loss before saturation is decided.
   localparam int SCR_D = DIGITS + 1;
   localparam int SCR_W = 4 * SCR_D;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_d;
   logic [BIN_W-1:0]     shreg_q, shreg_d;
   logic [SCR_W-1:0]     scr_q,   scr_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic [BCD_W-1:0]     bcd_q,   bcd_d;
   logic                 ovf_q,   ovf_d;

   logic [SCR_W-1:0]       scr_adj;
   logic [SCR_W+BIN_W-1:0] shifted;

   // Add-3 correction: each digit >= 5 gets +3 so the following left shift
   // carries into the next digit exactly when the doubled value passes 9.
   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i < SCR_D; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5)
            scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
      shifted = {scr_adj, shreg_q} << 1;
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               shreg_d = bin;
               scr_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_W'(BIN_W)) begin
               // Settle cycle: all shifts are in scratch, publish result.
               state_d = DONE;
               if (scr_q[SCR_W-1:BCD_W] != '0) begin
                  bcd_d = {DIGITS{4'h9}};
                  ovf_d = 1'b1;
               end else begin
                  bcd_d = scr_q[BCD_W-1:0];
                  ovf_d = 1'b0;
               end
            end else begin
               {scr_d, shreg_d} = shifted;
               cnt_d            = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   // busy covers only the shifting cycles; the settle cycle drops it so
   // busy and done can never overlap.
   assign busy = (state_q == SHIFT) && (cnt_q != CNT_W'(BIN_W));
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin14_to_bcd_seq.sv
module tb_bin14_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        busy, done, ovf;
   logic [15:0] bcd;

   bin14_to_bcd_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int          passed = 0;
   int          total  = 0;
   int          cyc    = 0;
   int          ndone  = 0;
   int          done_cyc = 0;
   logic [16:0] sb[$];
   logic [16:0] held = '0;

   function automatic logic [16:0] model(input int b);
      if (b > 9999) return {1'b1, 16'h9999};
      return {1'b0, 4'(b / 1000), 4'((b / 100) % 10), 4'((b / 10) % 10), 4'(b % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
   endtask

   // One clock: advance past the rising edge, then sample on the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!rst_n) begin
         chk("reset_out", {busy, done, ovf, bcd}, 32'h0);
         held = '0;
      end else begin
         if (done && busy) chk("done_busy_overlap", {busy, done}, 2'b01);
         if (done) begin
            ndone++;
            done_cyc = cyc;
            if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else chk("result", {ovf, bcd}, sb.pop_front());
            held = {ovf, bcd};
         end else if ({ovf, bcd} !== held) begin
            chk("hold", {ovf, bcd}, held);
         end
      end
   endtask

   task automatic wait_done(input int budget);
      int n0 = ndone;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (ndone != n0) return;
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_conv(input logic [13:0] b, input logic [16:0] e);
      start = 1'b1;
      bin   = b;
      tick();
      start = 1'b0;
      bin   = 14'($urandom);
      sb.push_back(e);
   endtask

   initial begin
      int edges, bcnt, v, prev_done;
      logic [13:0] r;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset", {busy, done, ovf, bcd}, 32'h0);

      // Latency and busy width with bin=0
      start_conv(14'd0, {1'b0, 16'h0000});
      edges = 1;
      bcnt  = busy ? 1 : 0;
      while (!done && edges < 40) begin
         tick();
         edges++;
         if (busy) bcnt++;
      end
      chk("latency_edges", edges, 16);
      chk("busy_cycles", bcnt, 14);
      tick();
      chk("done_one_cycle", done, 1'b0);

      // Directed values
      start_conv(14'd1234,  {1'b0, 16'h1234}); wait_done(40);
      start_conv(14'd9999,  {1'b0, 16'h9999}); wait_done(40);
      start_conv(14'd10000, {1'b1, 16'h9999}); wait_done(40);
      start_conv(14'd16383, {1'b1, 16'h9999}); wait_done(40);
      start_conv(14'd42,    {1'b0, 16'h0042}); wait_done(40);
      repeat (5) tick();
      chk("held_after_idle", {ovf, bcd}, {1'b0, 16'h0042});

      // Back-to-back with start held, crossing the overflow boundary
      v = 9997;
      start = 1'b1;
      bin   = 14'(v);
      tick();
      sb.push_back(model(v));
      prev_done = 0;
      for (int n = 0; n < 6; n++) begin
         wait_done(40);
         if (n > 0) chk("b2b_period", done_cyc - prev_done, 16);
         prev_done = done_cyc;
         if (n < 5) begin
            v++;
            bin = 14'(v);
            tick();
            sb.push_back(model(v));
         end else begin
            start = 1'b0;
         end
      end
      tick();
      chk("b2b_idle", {busy, done}, 2'b00);

      // Start while busy is ignored
      start_conv(14'd5678, {1'b0, 16'h5678});
      repeat (4) tick();
      chk("busy_at_pulse", busy, 1'b1);
      start = 1'b1;
      bin   = 14'd1;
      tick();
      start = 1'b0;
      wait_done(40);
      repeat (20) tick();
      chk("ignored_start", {ovf, bcd}, {1'b0, 16'h5678});

      // Reset mid-conversion aborts without a done
      start_conv(14'd4321, {1'b0, 16'h4321});
      repeat (6) tick();
      rst_n = 1'b0;
      sb.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("abort_state", {busy, done, ovf, bcd}, 32'h0);
      start_conv(14'd4321, {1'b0, 16'h4321}); wait_done(40);

      // Sweep: boundary region plus random values against the decimal model
      for (int b = 9990; b <= 10010; b++) begin
         start_conv(14'(b), model(b));
         wait_done(40);
      end
      for (int k = 0; k < 1500; k++) begin
         r = 14'($urandom);
         start_conv(r, model(int'(r)));
         wait_done(40);
      end
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
